// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, default SRAM geometry and response entry type for the request controller.
package sram_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 13;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned MEM_WORDS_DEF  = 6144;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] dat;
  } rsp_entry_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous FIFO; the head entry is visible combinationally, so a push shows up as non-empty on the next cycle.
// Push and pop may occur in the same cycle; a push while full is dropped unless a pop frees the slot in that cycle.
module sram_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = rsp_entry_t
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push_vld,
  input  entry_t                 push_dat,
  input  logic                   pop_vld,
  output entry_t                 head_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH);

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full     = (cnt_q == DEPTH_CNT);
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_vld & ~empty;
    do_push  = push_vld & (~full | do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
    end
    // Power-of-two depth, so pointer wrap is plain overflow.
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    cnt_d    = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready request front-end driving single-port SRAM pins, with optional zero-fill sweep after reset.
// Read data returns >=2 cycles after issue through a credit-guarded FIFO; req_ready drops when credits are exhausted.
module sram_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned MEM_WORDS     = MEM_WORDS_DEF,
  parameter int unsigned RSP_DEPTH     = 2,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic                  mem_CEB,
  output logic                  mem_WEB,
  output logic [DATA_WIDTH-1:0] mem_D,
  input  logic [DATA_WIDTH-1:0] mem_Q,
  output logic                  init_done
);

  localparam int unsigned           CW          = $clog2(RSP_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(MEM_WORDS - 1);
  localparam ctrl_state_t           RESET_STATE = INIT_ON_RESET ? INIT : RUN;

  typedef logic [DATA_WIDTH-1:0] dat_t;

  ctrl_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0] a_q, a_d;
  dat_t                  d_q, d_d;
  logic                  rd_inflight_q, rd_inflight_d;

  logic                  req_fire;
  logic                  rsp_pop;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count, credits;
  dat_t                  fifo_head;

  sram_rsp_fifo #(
    .DEPTH   (RSP_DEPTH),
    .entry_t (dat_t)
  ) u_rsp_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push_vld (rd_inflight_q),
    .push_dat (mem_Q),
    .pop_vld  (rsp_pop),
    .head_dat (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // An issued read reserves a FIFO slot until it is popped, so a push can never find the FIFO full.
  assign credits = fifo_count + CW'(rd_inflight_q);

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    a_d           = a_q;
    d_d           = d_q;
    rd_inflight_d = 1'b0;
    req_ready     = 1'b0;
    req_fire      = 1'b0;
    init_done     = 1'b0;
    mem_CEB       = 1'b1;
    mem_WEB       = 1'b1;
    mem_A         = a_q;
    mem_D         = d_q;
    rsp_valid     = ~RST & ~fifo_empty;
    rsp_pop       = rsp_valid & rsp_ready;
    rsp_data      = RST ? '0 : fifo_head;

    if (RST) begin
      mem_A = '0;
      mem_D = '0;
    end else begin
      case (state_q)
        INIT: begin
          mem_CEB    = 1'b0;
          mem_WEB    = 1'b0;
          mem_A      = init_cnt_q;
          mem_D      = '0;
          a_d        = init_cnt_q;
          d_d        = '0;
          init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
          if (init_cnt_q == LAST_ADDR) begin
            state_d = RUN;
          end
        end
        RUN: begin
          init_done = 1'b1;
          // A pop this cycle frees a slot, keeping back-to-back reads at full rate.
          req_ready = (~fifo_full & (credits < CW'(RSP_DEPTH))) | rsp_pop;
          req_fire  = req_valid & req_ready;
          if (req_fire) begin
            mem_CEB       = 1'b0;
            mem_WEB       = ~req_write;
            mem_A         = req_addr;
            mem_D         = req_wdata;
            a_d           = req_addr;
            d_d           = req_wdata;
            rd_inflight_d = ~req_write;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= RESET_STATE;
      init_cnt_q    <= '0;
      a_q           <= '0;
      d_q           <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      a_q           <= a_d;
      d_q           <= d_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Scoreboard bench for sram_req_ctrl: directed requests push expected read data, a monitor pops on rsp_valid&rsp_ready.
`timescale 1ns/1ps
module tb_sram_req_ctrl;

  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int WORDS = 6144;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready, rsp_valid, mem_CEB, mem_WEB, init_done;
  logic [DW-1:0] rsp_data, mem_D, mem_Q;
  logic [AW-1:0] mem_A;

  logic [DW-1:0] sram    [0:8191];
  bit            written [0:8191];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int outstanding  = 0;
  int last_rsp_cyc = 0;
  int prev_rsp_cyc = 0;
  logic [DW-1:0] exp_q [$];

  logic [AW-1:0] t4_addr [4] = '{13'h0400, 13'h1400, 13'h0005, 13'h17FF};
  logic [DW-1:0] t4_dat  [4] = '{16'h1111, 16'h2222, 16'hBEEF, 16'h0000};

  sram_req_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .MEM_WORDS     (WORDS),
    .RSP_DEPTH     (DEPTH),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_A     (mem_A),
    .mem_CEB   (mem_CEB),
    .mem_WEB   (mem_WEB),
    .mem_D     (mem_D),
    .mem_Q     (mem_Q),
    .init_done (init_done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM model: 1-cycle read latency, Q holds across writes and idle cycles; unwritten words read as A5A5.
  always @(posedge CLK) begin
    if (!mem_CEB) begin
      if (!mem_WEB) begin
        sram[mem_A]    <= mem_D;
        written[mem_A] <= 1'b1;
      end else begin
        mem_Q <= written[mem_A] ? sram[mem_A] : 16'hA5A5;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic monitor_loop();
    logic [DW-1:0] e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        outstanding = 0;
      end else begin
        if (req_valid && req_ready && !req_write) outstanding++;
        if (rsp_valid && rsp_ready) begin
          outstanding--;
          prev_rsp_cyc = last_rsp_cyc;
          last_rsp_cyc = cyc;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got %0h expected no response", rsp_data);
          end else begin
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e);
          end
        end
        if (outstanding > DEPTH) begin
          total++;
          bad++;
          $display("FAIL credit_overflow: got %0d outstanding reads expected at most %0d", outstanding, DEPTH);
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_d, output int fire_cyc);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    @(negedge CLK);
    while (!req_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    fire_cyc = cyc;
    if (req_ready) begin
      if (!wr) exp_q.push_back(exp_d);
    end else begin
      total++;
      bad++;
      $display("FAIL issue_timeout: addr %0h got no req_ready expected acceptance", a);
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_init(input string name, output int cycles);
    cycles = 0;
    while (!init_done && cycles < 7000) begin
      @(negedge CLK);
      if (!init_done) cycles++;
    end
    check({name, "_init_done"}, init_done, 1);
  endtask

  task automatic run_tests();
    int f, f2, n_ok, bad_a, idx, k;
    bit seen;

    // Reset values while RST is held.
    RST = 1'b1;
    rsp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data, 0);
    check("rst_mem_CEB",   mem_CEB, 1);
    check("rst_mem_WEB",   mem_WEB, 1);
    check("rst_mem_A",     mem_A, 0);
    check("rst_mem_D",     mem_D, 0);
    check("rst_init_done", init_done, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Zero-fill sweep: one write per cycle over 0..WORDS-1.
    n_ok = 0; bad_a = 0; idx = 0; seen = 0;
    while (!seen && idx < 7000) begin
      @(negedge CLK);
      if (init_done) begin
        seen = 1;
      end else begin
        if (!mem_CEB && !mem_WEB && mem_A == AW'(n_ok) && mem_D == '0 && !req_ready) n_ok++;
        else bad_a++;
        idx++;
      end
    end
    check("init_write_cycles", n_ok, WORDS);
    check("init_bad_cycles",   bad_a, 0);
    check("init_done_cycle",   idx, WORDS);
    check("init_ready_rise",   req_ready, 1);
    @(posedge CLK);
    #1;

    issue(1'b0, 13'h17FF, 16'h0, 16'h0000, f);
    wait_drain("t1");

    issue(1'b1, 13'h0005, 16'hBEEF, 16'h0, f);
    issue(1'b0, 13'h0005, 16'h0,    16'hBEEF, f);
    wait_drain("t2");
    check("t2_latency", last_rsp_cyc - f, 2);

    issue(1'b1, 13'h0400, 16'h1111, 16'h0, f);
    issue(1'b1, 13'h1400, 16'h2222, 16'h0, f);
    issue(1'b0, 13'h0400, 16'h0, 16'h1111, f);
    issue(1'b0, 13'h1400, 16'h0, 16'h2222, f2);
    wait_drain("t3");
    check("t3_back_to_back_issue", f2 - f, 1);
    check("t3_consecutive_rsp", last_rsp_cyc - prev_rsp_cyc, 1);

    // Four reads offered with the consumer stalled: only DEPTH may be accepted.
    rsp_ready = 1'b0;
    k = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = t4_addr[0];
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (req_ready) begin
        exp_q.push_back(t4_dat[k]);
        k++;
      end
      @(posedge CLK);
      #1;
      req_addr = t4_addr[k];
    end
    check("t4_accepted", k, 2);
    @(negedge CLK);
    check("t4_stall_ready", req_ready, 0);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    issue(1'b0, t4_addr[2], 16'h0, t4_dat[2], f);
    issue(1'b0, t4_addr[3], 16'h0, t4_dat[3], f);
    wait_drain("t4");

    issue(1'b0, 13'h0005, 16'h0, 16'hBEEF, f);
    issue(1'b1, 13'h0005, 16'h0000, 16'h0, f);
    issue(1'b0, 13'h0005, 16'h0, 16'h0000, f);
    wait_drain("t5");

    // Reset with one entry queued and one read in flight.
    rsp_ready = 1'b0;
    issue(1'b0, 13'h0400, 16'h0, 16'h1111, f);
    issue(1'b0, 13'h1400, 16'h0, 16'h2222, f);
    RST = 1'b1;
    exp_q.delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_mem_CEB",   mem_CEB, 0);
    check("t6_mem_A",     mem_A, 0);
    wait_init("t6", idx);
    check("t6_init_len", idx, WORDS - 1);
    check("t6_no_stale", rsp_valid, 0);
    @(posedge CLK);
    #1;
    issue(1'b0, 13'h0400, 16'h0, 16'h0000, f);
    wait_drain("t6");
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    fork
      monitor_loop();
      run_tests();
      begin
        #1000000;
        total++;
        bad++;
        $display("FAIL global_timeout: got no completion expected finish within budget");
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
